uart_loader_wbm: RTL and testbench

Wishbone master that bootstraps memory over the serial port. It drives the UART Wishbone slave (status/data and clock-divider registers) to program the baud divider, polls for received bytes, and parses a length-prefixed byte stream. It packs the payload into little-endian 32-bit words and writes them through a second Wishbone master port into RAM starting at `BASE_ADDR`. It sits directly upstream of the UART slave on the peripheral bus and alongside the CPU as a boot-time bus master.

---
 rtl/uart_loader_pkg.sv | 13 +
 rtl/uart_loader_wbm_byte_packer.sv | 33 +++
 rtl/uart_loader_wbm.sv | 144 ++++++++++++++
 tb/tb_uart_loader_wbm.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared states, UART register map and lane selects for the serial boot loader.
package uart_loader_pkg;
  typedef enum logic [3:0] {
    IDLE, SET_DIV, DIV_WAIT, POLL_REQ, POLL_WAIT, READ_REQ, READ_WAIT, STORE, MEM_WR, DONE, ERR
  } state_t;
  localparam logic SD = 1'b0;
  localparam logic CD = 1'b1;
  localparam int RXV = 8;
  localparam int TXB = 9;
  localparam logic [3:0] SEL_STAT = 4'b0010;
  localparam logic [3:0] SEL_DATA = 4'b0001;
  localparam logic [3:0] SEL_ALL = 4'hF;
endpackage

// File: rtl/uart_loader_wbm_byte_packer.sv
// byte_packer: packs bytes little-endian into 32-bit words, flagging a word on lane 3 or on the last byte.
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  input  logic        valid_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic [3:0]  mask_o,
  output logic        wvalid_o
);
  logic [1:0] lane_q, lane_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0] msk_q, msk_d;
  assign word_o = acc_q | ({24'b0, byte_i} << {lane_q, 3'b000});
  assign mask_o = msk_q | (4'b0001 << lane_q);
  assign wvalid_o = valid_i && (lane_q == 2'd3 || last_i);
  assign lane_d = !valid_i ? lane_q : wvalid_o ? 2'd0 : lane_q + 2'd1;
  assign acc_d = !valid_i ? acc_q : wvalid_o ? 32'd0 : word_o;
  assign msk_d = !valid_i ? msk_q : wvalid_o ? 4'd0 : mask_o;
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      lane_q <= '0;
      acc_q <= '0;
      msk_q <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q <= acc_d;
      msk_q <= msk_d;
    end
  end
endmodule

// File: rtl/uart_loader_wbm.sv
// uart_loader_wbm: boot-time Wishbone master that reads a length-prefixed UART stream into RAM.
module uart_loader_wbm
  import uart_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] UART_DIV = 32'd1,
  parameter logic [31:0] MAX_BYTES = 32'd65536
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:2]  uart_adr_o,
  output logic [31:0] uart_dat_o,
  input  logic [31:0] uart_dat_i,
  output logic        uart_we_o,
  output logic [3:0]  uart_sel_o,
  output logic        uart_stb_o,
  input  logic        uart_ack_i,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_stb_o,
  input  logic        mem_ack_i
);
  state_t state_q, state_d;
  logic [31:0] len_q, len_d, cnt_q, cnt_d, widx_q, widx_d, wdat_q, wdat_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0] wsel_q, wsel_d;
  logic last_q, last_d, done_q, done_d, err_q, err_d;
  logic [31:0] len_new, pk_word;
  logic [3:0] pk_mask;
  logic hdr, last, pk_valid, pk_wvalid, accept, unused;
  assign accept = state_q == IDLE && start_i;
  assign hdr = cnt_q < 32'd4;
  assign len_new = {byte_q, len_q[31:8]};
  assign last = cnt_q == len_q + 32'd3;
  assign pk_valid = state_q == STORE && !hdr;
  assign unused = ^{uart_dat_i[31:TXB], widx_q[31:30]};
  byte_packer u_packer (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .clr_i(accept), .byte_i(byte_q), .valid_i(pk_valid),
    .last_i(last), .word_o(pk_word), .mask_o(pk_mask), .wvalid_o(pk_wvalid)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    widx_d = widx_q;
    wdat_d = wdat_q;
    wsel_d = wsel_q;
    byte_d = byte_q;
    last_d = last_q;
    done_d = done_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = SET_DIV;
        done_d = 1'b0;
        err_d = 1'b0;
        len_d = '0;
        cnt_d = '0;
        widx_d = '0;
      end
      SET_DIV: state_d = DIV_WAIT;
      DIV_WAIT: state_d = uart_ack_i ? POLL_REQ : DIV_WAIT;
      POLL_REQ: state_d = POLL_WAIT;
      POLL_WAIT: state_d = !uart_ack_i ? POLL_WAIT : uart_dat_i[RXV] ? READ_REQ : POLL_REQ;
      READ_REQ: state_d = READ_WAIT;
      READ_WAIT: if (uart_ack_i) begin
        byte_d = uart_dat_i[7:0];
        state_d = STORE;
      end
      STORE: begin
        cnt_d = cnt_q + 32'd1;
        if (hdr) begin
          len_d = len_new;
          state_d = cnt_q != 32'd3 ? POLL_REQ : len_new == '0 ? DONE : len_new > MAX_BYTES ? ERR : POLL_REQ;
        end else if (pk_wvalid) begin
          wdat_d = pk_word;
          wsel_d = pk_mask;
          last_d = last;
          state_d = MEM_WR;
        end else begin
          state_d = POLL_REQ;
        end
      end
      MEM_WR: if (mem_ack_i) begin
        widx_d = widx_q + 32'd1;
        state_d = last_q ? DONE : POLL_REQ;
      end
      DONE: begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      widx_q <= '0;
      wdat_q <= '0;
      wsel_q <= '0;
      byte_q <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      widx_q <= widx_d;
      wdat_q <= wdat_d;
      wsel_q <= wsel_d;
      byte_q <= byte_d;
      last_q <= last_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // Outputs are gated by reset so strobes drop in the very cycle reset is raised.
  assign busy_o = !wb_rst_i && !(state_q inside {IDLE, DONE, ERR});
  assign done_o = !wb_rst_i && (done_q || state_q == DONE);
  assign err_o = !wb_rst_i && (err_q || state_q == ERR);
  assign uart_stb_o = !wb_rst_i && state_q inside {SET_DIV, POLL_REQ, READ_REQ};
  assign uart_we_o = !wb_rst_i && state_q == SET_DIV;
  assign uart_adr_o = uart_we_o ? CD : SD;
  assign uart_dat_o = uart_we_o ? UART_DIV : 32'd0;
  assign uart_sel_o = !uart_stb_o ? 4'd0 : uart_we_o ? SEL_ALL : state_q == POLL_REQ ? SEL_STAT : SEL_DATA;
  assign mem_stb_o = !wb_rst_i && state_q == MEM_WR;
  assign mem_we_o = mem_stb_o;
  assign mem_adr_o = mem_stb_o ? BASE_ADDR + {widx_q[29:0], 2'b00} : 32'd0;
  assign mem_dat_o = mem_stb_o ? wdat_q : 32'd0;
  assign mem_sel_o = mem_stb_o ? wsel_q : 4'd0;
endmodule

// File: tb/tb_uart_loader_wbm.sv
// tb_uart_loader_wbm: UART and RAM slave models plus a stream-level model of the expected RAM writes.
module tb_uart_loader_wbm;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [31:0] DIV = 32'd5;
  localparam logic [31:0] MAXB = 32'h10000;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] s;} wr_t;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0;
  logic busy_o, done_o, err_o, uart_we_o, uart_stb_o, mem_we_o, mem_stb_o;
  logic [2:2] uart_adr_o;
  logic [31:0] uart_dat_o, mem_adr_o, mem_dat_o;
  logic [3:0] uart_sel_o, mem_sel_o;
  logic [31:0] u_rdat = '0, u_pdat = '0;
  logic u_ack = 1'b0, u_pend = 1'b0, u_prev = 1'b0, armed = 1'b0, mem_ack = 1'b0, mheld = 1'b0;
  logic [7:0] stream [64];
  int slen = 0, gap = 0, mdly = 0, rx_idx = 0, hold = 0, mwait = 0;
  int n_div = 0, n_poll = 0, n_rd = 0, bad_div = 0, bad_rd = 0, bad_stb = 0;
  int munstable = 0, bad_we = 0, bad_drop = 0;
  int n_tests = 0, n_fail = 0, consumed = 0;
  logic exp_done, exp_err;
  logic [31:0] sadr, sdat;
  logic [3:0] ssel;
  wr_t got[$], expq[$];
  always #5 clk = ~clk;
  uart_loader_wbm #(.BASE_ADDR(BASE), .UART_DIV(DIV), .MAX_BYTES(MAXB)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .uart_adr_o(uart_adr_o), .uart_dat_o(uart_dat_o), .uart_dat_i(u_rdat), .uart_we_o(uart_we_o),
    .uart_sel_o(uart_sel_o), .uart_stb_o(uart_stb_o), .uart_ack_i(u_ack), .mem_adr_o(mem_adr_o),
    .mem_dat_o(mem_dat_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_stb_o(mem_stb_o),
    .mem_ack_i(mem_ack)
  );
  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask
  // Registered UART slave (ack one cycle after strobe) and classic RAM slave with programmable wait.
  always @(negedge clk) begin
    u_ack = u_pend;
    u_rdat = u_pend ? u_pdat : 32'd0;
    u_pend = 1'b0;
    if (uart_stb_o) begin
      if (u_prev) bad_stb++;
      u_pend = 1'b1;
      u_pdat = '0;
      u_pdat[9] = 1'($urandom);
      if (uart_we_o) begin
        rx_idx = 0; hold = gap; armed = 1'b0;
        n_div = 1; n_poll = 0; n_rd = 0; bad_div = 0; bad_rd = 0; bad_stb = 0;
        munstable = 0; bad_we = 0; bad_drop = 0;
        got.delete();
        if (uart_adr_o !== 1'b1 || uart_dat_o !== DIV || uart_sel_o !== 4'hF) bad_div++;
      end else if (uart_adr_o === 1'b0 && uart_sel_o === 4'b0010) begin
        n_poll++;
        if (hold > 0) hold--;
        else if (rx_idx < slen) begin
          u_pdat[8] = 1'b1;
          armed = 1'b1;
        end
      end else if (uart_adr_o === 1'b0 && uart_sel_o === 4'b0001) begin
        n_rd++;
        if (!armed || rx_idx >= slen) bad_rd++;
        else begin
          u_pdat[7:0] = stream[rx_idx];
          rx_idx++;
          armed = 1'b0;
          hold = gap;
        end
      end else bad_rd++;
    end
    u_prev = uart_stb_o;
    if (mem_ack) begin
      if (mem_stb_o) bad_drop++;
      mem_ack = 1'b0;
    end else if (mem_stb_o) begin
      if (!mem_we_o) bad_we++;
      if (!mheld) begin
        mheld = 1'b1; mwait = 0; sadr = mem_adr_o; sdat = mem_dat_o; ssel = mem_sel_o;
      end else if ({mem_adr_o, mem_dat_o, mem_sel_o} !== {sadr, sdat, ssel}) munstable++;
      if (mwait >= mdly) begin
        mem_ack = 1'b1;
        got.push_back('{mem_adr_o, mem_dat_o, mem_sel_o});
        mheld = 1'b0;
      end else mwait++;
    end else mheld = 1'b0;
  end
  task automatic start_load(input logic [7:0] b[$], input int g, input int d);
    logic [31:0] n, wd;
    logic [3:0] ws;
    n = {b[3], b[2], b[1], b[0]};
    foreach (b[i]) stream[i] = b[i];
    slen = b.size();
    gap = g;
    mdly = d;
    expq.delete();
    exp_done = n <= MAXB;
    exp_err = n > MAXB;
    consumed = (n == 0 || n > MAXB) ? 4 : 4 + int'(n);
    if (n != 0 && n <= MAXB)
      for (int w = 0; w < (int'(n) + 3) / 4; w++) begin
        wd = '0;
        ws = '0;
        for (int j = 0; j < 4; j++)
          if (4 * w + j < int'(n)) begin
            wd = wd | (32'(b[4 + 4 * w + j]) << (8 * j));
            ws[j] = 1'b1;
          end
        expq.push_back('{BASE + 32'(4 * w), wd, ws});
      end
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    check("accept_busy", 32'(busy_o), 32'd1);
    check("accept_flags_clear", {30'd0, done_o, err_o}, 32'd0);
  endtask
  task automatic finish_load(input string tag);
    int cyc = 0;
    while (!(done_o || err_o) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 5000), 32'd1);
    check({tag, "_done_err_busy"}, {29'd0, done_o, err_o, busy_o}, {29'd0, exp_done, exp_err, 1'b0});
    check({tag, "_nwrites"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      check({tag, "_wr_adr"}, got[i].a, expq[i].a);
      check({tag, "_wr_dat"}, got[i].d, expq[i].d);
      check({tag, "_wr_sel"}, 32'(got[i].s), 32'(expq[i].s));
    end
    check({tag, "_div_writes"}, 32'(n_div), 32'd1);
    check({tag, "_bytes_read"}, 32'(n_rd), 32'(consumed));
    check({tag, "_protocol"}, 32'(bad_div + bad_rd + bad_stb + munstable + bad_we + bad_drop), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_flags_held"}, {29'd0, done_o, err_o, busy_o}, {29'd0, exp_done, exp_err, 1'b0});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] b[$];
    logic [31:0] n;
    int cyc;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(|{busy_o, done_o, err_o, uart_stb_o, uart_we_o, uart_sel_o, uart_adr_o,
      uart_dat_o, mem_stb_o, mem_we_o, mem_sel_o, mem_adr_o, mem_dat_o}), 32'd0);
    rst = 1'b0;
    b = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    start_load(b, 0, 7);
    finish_load("full_words");
    b = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    start_load(b, 1, 0);
    finish_load("partial_word");
    b = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h12, 8'h34};
    start_load(b, 0, 0);
    finish_load("too_long");
    b = '{8'h00, 8'h00, 8'h00, 8'h00};
    start_load(b, 20, 0);
    finish_load("zero_len");
    check("zero_len_polls", 32'(n_poll >= 4 * 21), 32'd1);
    for (int t = 0; t < 8; t++) begin
      n = (t == 7) ? MAXB + 32'd1 + $urandom_range(0, 1000) : 32'($urandom_range(1, 13));
      b = '{n[7:0], n[15:8], n[23:16], n[31:24]};
      for (int k = 0; k < ((t == 7) ? 3 : int'(n)); k++) b.push_back(8'($urandom));
      start_load(b, $urandom_range(0, 3), $urandom_range(0, 4));
      finish_load("random");
    end
    b = '{8'h10, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 16; k++) b.push_back(8'($urandom));
    start_load(b, 0, 7);
    cyc = 0;
    while (!mem_stb_o && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reset_reached_write", 32'(mem_stb_o), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", 32'(|{busy_o, done_o, err_o, uart_stb_o, mem_stb_o, mem_sel_o, mem_adr_o}), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("after_reset_idle", 32'(|{busy_o, done_o, err_o, uart_stb_o, mem_stb_o}), 32'd0);
    b = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    start_load(b, 2, 3);
    finish_load("restart");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
